// File: rtl/control_pkg.sv
// control_pkg: shared types and constants for the pipelined RV32I control unit.
// Provides opcode constants, ALU/immediate/result-select encodings, the packed
// control word carried down the pipeline, and the funct3-to-ALU-op helper.
package control_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } immsrc_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } resultsrc_t;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alusrc;
        alu_op_t    alucontrol;
        resultsrc_t resultsrc;
        logic       illegal;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_BUBBLE = '0;

    // alt selects SUB for funct3 000 and SRA for funct3 101; callers gate it.
    function automatic alu_op_t alu_from_funct3(logic [2:0] funct3, logic alt);
        alu_op_t op;
        unique case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_decoder.sv
// control_decoder: purely combinational main decoder.
// Ports:
//   i_op, i_funct3, i_funct7b5 : instruction fields in Decode
//   o_ctrl                     : control word (bubble with illegal=1 if undecodable)
//   o_immsrc                   : extend-unit select
module control_decoder
    import control_pkg::*;
#(
    parameter int unsigned SUPPORT_UPPER        = 1,
    parameter int unsigned SUPPORT_ALL_BRANCHES = 1
) (
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output ctrl_word_t o_ctrl,
    output logic [2:0] o_immsrc
);

    ctrl_word_t w_ctrl;
    immsrc_t    w_immsrc;
    logic       w_legal;

    always_comb begin
        w_ctrl   = CTRL_BUBBLE;
        w_immsrc = IMM_I;
        w_legal  = 1'b1;
        unique case (i_op)
            OP_LOAD: begin
                // lb, lh, lw, lbu, lhu
                w_legal = (i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                w_ctrl.regwrite   = 1'b1;
                w_ctrl.alusrc     = 1'b1;
                w_ctrl.alucontrol = ALU_ADD;
                w_ctrl.resultsrc  = RES_MEM;
                w_immsrc          = IMM_I;
            end
            OP_IMM: begin
                w_ctrl.regwrite   = 1'b1;
                w_ctrl.alusrc     = 1'b1;
                w_ctrl.alucontrol = alu_from_funct3(i_funct3,
                                                    i_funct7b5 && (i_funct3 == 3'b101));
                w_immsrc          = IMM_I;
            end
            OP_REG: begin
                w_ctrl.regwrite   = 1'b1;
                w_ctrl.alucontrol = alu_from_funct3(i_funct3, i_funct7b5);
            end
            OP_STORE: begin
                // sb, sh, sw
                w_legal = (i_funct3 inside {3'b000, 3'b001, 3'b010});
                w_ctrl.memwrite   = 1'b1;
                w_ctrl.alusrc     = 1'b1;
                w_ctrl.alucontrol = ALU_ADD;
                w_immsrc          = IMM_S;
            end
            OP_BRANCH: begin
                if (i_funct3 == 3'b000) begin
                    w_legal = 1'b1;
                end else if (SUPPORT_ALL_BRANCHES != 0) begin
                    w_legal = (i_funct3 inside {3'b001, 3'b100, 3'b101, 3'b110, 3'b111});
                end else begin
                    w_legal = 1'b0;
                end
                w_ctrl.branch     = 1'b1;
                w_ctrl.alucontrol = ALU_SUB;
                w_immsrc          = IMM_B;
            end
            OP_JAL: begin
                w_ctrl.regwrite  = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_ctrl.resultsrc = RES_PC4;
                w_immsrc         = IMM_J;
            end
            OP_JALR: begin
                w_legal = (i_funct3 == 3'b000);
                w_ctrl.regwrite   = 1'b1;
                w_ctrl.jump       = 1'b1;
                w_ctrl.jalr       = 1'b1;
                w_ctrl.alusrc     = 1'b1;
                w_ctrl.alucontrol = ALU_ADD;
                w_ctrl.resultsrc  = RES_PC4;
                w_immsrc          = IMM_I;
            end
            OP_LUI: begin
                w_legal = (SUPPORT_UPPER != 0);
                w_ctrl.regwrite  = 1'b1;
                w_ctrl.resultsrc = RES_IMM;
                w_immsrc         = IMM_U;
            end
            OP_AUIPC: begin
                // Datapath steers pc onto ALU A for this opcode.
                w_legal = (SUPPORT_UPPER != 0);
                w_ctrl.regwrite   = 1'b1;
                w_ctrl.alusrc     = 1'b1;
                w_ctrl.alucontrol = ALU_ADD;
                w_immsrc          = IMM_U;
            end
            default: w_legal = 1'b0;
        endcase

        // Anything undecodable leaves as a bubble tagged illegal.
        if (!w_legal) begin
            w_ctrl         = CTRL_BUBBLE;
            w_ctrl.illegal = 1'b1;
            w_immsrc       = IMM_I;
        end
    end

    assign o_ctrl   = w_ctrl;
    assign o_immsrc = w_immsrc;

endmodule

// File: rtl/control_pipeline.sv
// control_pipeline: pipelined control for the five-stage RV32I core.
// Decodes in D, registers the control word into E, M and W, and resolves the
// next-PC select in E from the ALU flags.
// Ports:
//   clk, rst                     : clock, async active-high reset
//   op_d, funct3_d, funct7b5_d   : Decode instruction fields
//   stall_e, flush_e             : hold / bubble the Execute register
//   zero_e, lt_e, ltu_e          : ALU flags for branch resolution
//   immsrc_d                     : combinational extend select
//   alusrc_e .. illegal_e        : Execute-stage controls and pcsrc
//   regwrite_m, memwrite_m, funct3_m : Memory-stage controls
//   regwrite_w, resultsrc_w      : Writeback-stage controls
module control_pipeline
    import control_pkg::*;
#(
    parameter int unsigned SUPPORT_UPPER        = 1,
    parameter int unsigned SUPPORT_ALL_BRANCHES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_d,
    input  logic [2:0] funct3_d,
    input  logic       funct7b5_d,
    input  logic       stall_e,
    input  logic       flush_e,
    input  logic       zero_e,
    input  logic       lt_e,
    input  logic       ltu_e,
    output logic [2:0] immsrc_d,
    output logic       alusrc_e,
    output logic [3:0] alucontrol_e,
    output logic [1:0] pcsrc_e,
    output logic [1:0] resultsrc_e,
    output logic       illegal_e,
    output logic       regwrite_m,
    output logic       memwrite_m,
    output logic [2:0] funct3_m,
    output logic       regwrite_w,
    output logic [1:0] resultsrc_w
);

    ctrl_word_t w_ctrl_d;
    logic [2:0] w_funct3_d;
    logic       w_taken;

    ctrl_word_t r_ctrl_e;
    logic [2:0] r_funct3_e;
    logic       r_regwrite_m;
    logic       r_memwrite_m;
    resultsrc_t r_resultsrc_m;
    logic [2:0] r_funct3_m;
    logic       r_regwrite_w;
    resultsrc_t r_resultsrc_w;

    control_decoder #(
        .SUPPORT_UPPER       (SUPPORT_UPPER),
        .SUPPORT_ALL_BRANCHES(SUPPORT_ALL_BRANCHES)
    ) u_decoder (
        .i_op      (op_d),
        .i_funct3  (funct3_d),
        .i_funct7b5(funct7b5_d),
        .o_ctrl    (w_ctrl_d),
        .o_immsrc  (immsrc_d)
    );

    // Illegal instructions travel as true bubbles, funct3 included.
    assign w_funct3_d = w_ctrl_d.illegal ? 3'b000 : funct3_d;

    // D -> E: flush has priority over stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl_e   <= CTRL_BUBBLE;
            r_funct3_e <= 3'b000;
        end else if (flush_e) begin
            r_ctrl_e   <= CTRL_BUBBLE;
            r_funct3_e <= 3'b000;
        end else if (!stall_e) begin
            r_ctrl_e   <= w_ctrl_d;
            r_funct3_e <= w_funct3_d;
        end
    end

    // E -> M: a held Execute instruction must not also enter Memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regwrite_m  <= 1'b0;
            r_memwrite_m  <= 1'b0;
            r_resultsrc_m <= RES_ALU;
            r_funct3_m    <= 3'b000;
        end else if (stall_e && !flush_e) begin
            r_regwrite_m  <= 1'b0;
            r_memwrite_m  <= 1'b0;
            r_resultsrc_m <= RES_ALU;
            r_funct3_m    <= 3'b000;
        end else begin
            r_regwrite_m  <= r_ctrl_e.regwrite;
            r_memwrite_m  <= r_ctrl_e.memwrite;
            r_resultsrc_m <= r_ctrl_e.resultsrc;
            r_funct3_m    <= r_funct3_e;
        end
    end

    // M -> W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regwrite_w  <= 1'b0;
            r_resultsrc_w <= RES_ALU;
        end else begin
            r_regwrite_w  <= r_regwrite_m;
            r_resultsrc_w <= r_resultsrc_m;
        end
    end

    always_comb begin
        w_taken = 1'b0;
        unique case (r_funct3_e)
            3'b000:  w_taken = zero_e;
            3'b001:  w_taken = !zero_e;
            3'b100:  w_taken = lt_e;
            3'b101:  w_taken = !lt_e;
            3'b110:  w_taken = ltu_e;
            3'b111:  w_taken = !ltu_e;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        pcsrc_e = 2'b00;
        if (r_ctrl_e.jalr) begin
            pcsrc_e = 2'b10;
        end else if (r_ctrl_e.jump || (r_ctrl_e.branch && w_taken)) begin
            pcsrc_e = 2'b01;
        end
    end

    assign alusrc_e     = r_ctrl_e.alusrc;
    assign alucontrol_e = r_ctrl_e.alucontrol;
    assign resultsrc_e  = r_ctrl_e.resultsrc;
    assign illegal_e    = r_ctrl_e.illegal;
    assign regwrite_m   = r_regwrite_m;
    assign memwrite_m   = r_memwrite_m;
    assign funct3_m     = r_funct3_m;
    assign regwrite_w   = r_regwrite_w;
    assign resultsrc_w  = r_resultsrc_w;

endmodule

// File: doc/control_pipeline.md
# control_pipeline

Pipelined control unit for the five-stage RV32I core: decodes the instruction in Decode, carries the control word through Execute, Memory and Writeback registers, and resolves the next-PC select in Execute from ALU flags. It replaces the single-cycle main decoder and adds:
- stall and flush handling, with bubbles as all-zero control words;
- a parametrised instruction-subset mode;
- illegal-opcode detection.

## Interface
Parameters:
- SUPPORT_UPPER, default 1: decode lui/auipc; when 0 they are illegal.
- SUPPORT_ALL_BRANCHES, default 1: decode bne/blt/bge/bltu/bgeu; when 0 only beq is legal.

Ports:
- clk  in  1  core clock; all registers update on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_d  in  7  opcode of the instruction in Decode.
- funct3_d  in  3  funct3 field.
- funct7b5_d  in  1  instruction bit 30.
- stall_e  in  1  hold the Execute register.
- flush_e  in  1  load a bubble into the Execute register.
- zero_e, lt_e, ltu_e  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
- immsrc_d  out  3  extend-unit select (combinational).
- alusrc_e  out  1  ALU B operand: 0 = register, 1 = immediate.
- alucontrol_e  out  4  ALU operation.
- pcsrc_e  out  2  next PC: 00 = pc+4, 01 = pc+imm, 10 = ALU result (jalr).
- resultsrc_e  out  2  for hazard-unit load detection.
- illegal_e  out  1  the instruction now in Execute was undecodable.
- regwrite_m, memwrite_m  out  1 each.
- funct3_m  out  3  load/store width for the memory stage.
- regwrite_w  out  1.
- resultsrc_w  out  2  00 = ALU, 01 = memory, 10 = pc+4, 11 = immediate (lui).

## Operation
Decode is combinational on op_d, funct3_d and funct7b5_d.

- **lw**: regwrite, I-imm, alusrc, ADD, resultsrc 01.
- **I-type**: regwrite, I-imm, alusrc, ALU op from funct3; funct7b5 selects SRA vs SRL for funct3 101 only.
- **R-type**: regwrite, funct7b5 selects SUB/SRA.
- **sw**: memwrite, S-imm, alusrc, ADD.
- **Branch** (funct3 000, 001, 100, 101, 110, 111): branch, B-imm, SUB.
- **jal**: regwrite, jump, J-imm, resultsrc 10.
- **jalr**: regwrite, jump, jalr, I-imm, alusrc, ADD, resultsrc 10.
- **lui**: regwrite, U-imm, resultsrc 11.
- **auipc**: regwrite, U-imm, alusrc, ADD on pc.
- **Any other opcode/funct3**, or any instruction excluded by a parameter: the control word is all zero and illegal = 1. The decoder never outputs all-ones.

Encodings:
- ALU: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- immsrc: I 000, S 001, B 010, J 011, U 100.

Pipeline registers: D→E (full control word plus funct3), E→M (regwrite, memwrite, resultsrc, funct3), M→W (regwrite, resultsrc).

pcsrc_e is combinational from the Execute register and flags:
- jalr: 10.
- jump: 01.
- branch taken: 01. Taken is beq:zero, bne:!zero, blt:lt, bge:!lt, bltu:ltu, bgeu:!ltu.
- otherwise: 00.

Stall and flush:
- flush_e: the Execute register loads a bubble.
- stall_e without flush: the Execute register holds its value and Memory receives a bubble.
- flush_e and stall_e together: flush wins.
- Memory and Writeback always advance.

## Timing
- An instruction decoded in cycle n shows its _e outputs in n+1, _m in n+2 and _w in n+3.
- immsrc_d has zero latency.
- pcsrc_e is valid in the same cycle as the _e registers, with no added register.
- Reset clears every register asynchronously to a bubble: all _e, _m and _w outputs are 0, pcsrc_e = 00 and illegal_e = 0.
- Release of rst is synchronised externally.
- Reset asserted mid-pipeline discards all in-flight control words.
- An illegal instruction travels as a bubble. illegal_e is high for exactly its Execute cycle, or longer while it is held by stall_e.

## Structure
- Package control_pkg holds:
  - opcode constants;
  - alu_op_t, immsrc_t and resultsrc_t enums with the encodings above;
  - packed struct ctrl_word_t (regwrite, memwrite, branch, jump, jalr, alusrc, alucontrol, resultsrc, illegal);
  - constant CTRL_BUBBLE, all zero.
- One sub-module: control_decoder, the purely combinational decode to ctrl_word_t, taking the same two parameters.
- control_pipeline instantiates control_decoder and contains the stage registers and the branch-resolution logic.

## Test plan
- **Reset:** assert rst mid-stream with regwrite_w = 1 in flight → all outputs drop to 0 in the same cycle, without waiting for clk.
- **Basic pipeline:** op_d = 0000011 (lw) at cycle 0 → resultsrc_e = 01 and alucontrol_e = 0000 at cycle 1, regwrite_m = 1 at cycle 2, resultsrc_w = 01 at cycle 3.
- **Branches:** bne (funct3 001) with zero_e = 0 → pcsrc_e = 01; with zero_e = 1 → 00. bgeu with ltu_e = 1 → 00. jalr → pcsrc_e = 10.
- **Stall/flush:** stall_e = 1 for 2 cycles holding sw → memwrite_m = 0 for those cycles, then 1 for one cycle. stall_e and flush_e together → Execute register is a bubble.
- **Parameters:** SUPPORT_UPPER = 0 with op 0110111 → illegal_e = 1 and regwrite_w stays 0. SUPPORT_ALL_BRANCHES = 0 with blt → illegal_e = 1 and pcsrc_e = 00.
- **Illegal opcode:** op_d = 1111111 → all control 0, illegal_e = 1 for one cycle.
